// File: rtl/buffer_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : buffer_sched_pkg
//  Purpose  : Shared buffer state encoding and width helpers for the
//             buffer_scheduler slice.
//  Revision : 1.0  initial release
// ============================================================================
package buffer_sched_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } buf_state_t;

    // Index widths never collapse to zero bits, even for a single buffer/tile.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/buffer_scheduler_rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rw_arbiter
//  Purpose  : Two-requester write/read arbiter; alternates priority on
//             contested cycles, grants are mutually exclusive.
//  Revision : 1.0  initial release
// ============================================================================
module rw_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    // High when the read side is owed the next contested cycle.
    logic r_rd_first;

    always_comb begin
        gnt_wr = req_wr && !(req_rd && r_rd_first);
        gnt_rd = req_rd && !gnt_wr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_first <= 1'b0;
        end else if (req_wr && req_rd) begin
            r_rd_first <= gnt_wr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/buffer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : buffer_scheduler
//  Purpose  : Allocation, tile counting and read/write sequencing for an
//             N-way ping-pong buffer_file.
//  Revision : 1.0  initial release
// ============================================================================
module buffer_scheduler
    import buffer_sched_pkg::*;
#(
    parameter int BUFFER_COUNT     = 2,
    parameter int TILES_PER_BUFFER = 4,
    parameter int TILE_WIDTH       = 256
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic [TILE_WIDTH-1:0]                in_data,
    output logic                                 in_ready,
    input  logic                                 out_req,
    output logic                                 out_valid,
    output logic                                 out_last,
    output logic                                 bf_write_enable,
    output logic [TILE_WIDTH-1:0]                bf_write_data,
    output logic [ptr_width(BUFFER_COUNT)-1:0]   bf_write_buffer,
    output logic                                 bf_read_enable,
    output logic [ptr_width(BUFFER_COUNT)-1:0]   bf_read_buffer,
    input  logic                                 bf_writing_done,
    input  logic                                 bf_reading_done,
    output logic [count_width(BUFFER_COUNT)-1:0] full_count,
    output logic                                 error
);

    localparam int c_PW = ptr_width(BUFFER_COUNT);
    localparam int c_CW = cnt_width(TILES_PER_BUFFER);
    localparam int c_FW = count_width(BUFFER_COUNT);

    localparam logic [c_CW-1:0] c_LAST_TILE = c_CW'(TILES_PER_BUFFER - 1);
    localparam logic [c_PW-1:0] c_LAST_BUF  = c_PW'(BUFFER_COUNT - 1);

    buf_state_t      r_state [BUFFER_COUNT];
    logic [c_PW-1:0] r_wr_sel;
    logic [c_PW-1:0] r_rd_sel;
    logic [c_CW-1:0] r_wr_cnt;
    logic [c_CW-1:0] r_rd_cnt;
    logic            r_out_valid;
    logic            r_out_last;
    logic            r_exp_wdone;
    logic            r_error;

    logic            w_wr_elig;
    logic            w_rd_elig;
    logic            w_gnt_wr;
    logic            w_gnt_rd;
    logic            w_wr_last;
    logic            w_rd_last;
    logic [c_FW-1:0] w_full_count;

    always_comb begin
        w_wr_elig = (r_state[r_wr_sel] == EMPTY) || (r_state[r_wr_sel] == FILLING);
        w_rd_elig = out_req &&
                    ((r_state[r_rd_sel] == FULL) || (r_state[r_rd_sel] == DRAINING));
        w_wr_last = (r_wr_cnt == c_LAST_TILE);
        w_rd_last = (r_rd_cnt == c_LAST_TILE);
    end

    rw_arbiter u_arbiter (
        .clk    (clk),
        .reset  (reset),
        .req_wr (w_wr_elig),
        .req_rd (w_rd_elig),
        .gnt_wr (w_gnt_wr),
        .gnt_rd (w_gnt_rd)
    );

    // No buffer_file access is issued while reset is asserted.
    assign in_ready        = w_gnt_wr && !reset;
    assign bf_write_enable = in_valid && in_ready;
    assign bf_write_data   = in_data;
    assign bf_write_buffer = r_wr_sel;
    assign bf_read_enable  = w_gnt_rd && !reset;
    assign bf_read_buffer  = r_rd_sel;

    always_comb begin
        w_full_count = '0;
        for (int i = 0; i < BUFFER_COUNT; i++) begin
            if ((r_state[i] == FULL) || (r_state[i] == DRAINING)) begin
                w_full_count = w_full_count + c_FW'(1);
            end
        end
    end

    assign full_count = w_full_count;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign error      = r_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUFFER_COUNT; i++) begin
                r_state[i] <= EMPTY;
            end
            r_wr_sel    <= '0;
            r_rd_sel    <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_exp_wdone <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (bf_write_enable) begin
                if (w_wr_last) begin
                    r_state[r_wr_sel] <= FULL;
                    r_wr_cnt          <= '0;
                    r_wr_sel          <= (r_wr_sel == c_LAST_BUF) ? '0 : r_wr_sel + 1'b1;
                end else begin
                    r_state[r_wr_sel] <= FILLING;
                    r_wr_cnt          <= r_wr_cnt + 1'b1;
                end
            end
            // Grants are exclusive, so the read update never touches the
            // buffer written above in the same cycle.
            if (bf_read_enable) begin
                if (w_rd_last) begin
                    r_state[r_rd_sel] <= EMPTY;
                    r_rd_cnt          <= '0;
                    r_rd_sel          <= (r_rd_sel == c_LAST_BUF) ? '0 : r_rd_sel + 1'b1;
                end else begin
                    r_state[r_rd_sel] <= DRAINING;
                    r_rd_cnt          <= r_rd_cnt + 1'b1;
                end
            end
            r_out_valid <= bf_read_enable;
            r_out_last  <= bf_read_enable && w_rd_last;
            r_exp_wdone <= bf_write_enable && w_wr_last;
            if ((bf_writing_done != r_exp_wdone) || (bf_reading_done != r_out_last)) begin
                r_error <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
